// File: rtl/conv_encoder_framer.sv
// Rate-1/2, K=3 convolutional encoder with a message/symbol handshake.
// Takes one SEQ_WIDTH-bit message, emits it MSB-first as 2-bit coded symbols
// {c1,c0}. The generators are G0=111 (c1) and G1=101 (c0). Optional zero tail
// bits drive the trellis back to state 00.
module conv_encoder_framer #(
   parameter int SEQ_WIDTH  = 5,
   parameter int DATA_WIDTH = 2,
   parameter int TAIL_EN    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  msg_valid,
   output logic                  msg_ready,
   input  logic [SEQ_WIDTH-1:0]  msg_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_start,
   output logic                  tx_last,
   output logic [1:0]            enc_state
);

   localparam int FRAME_LEN = (TAIL_EN != 0) ? SEQ_WIDTH + 2 : SEQ_WIDTH;
   localparam int CNT_W     = $clog2(SEQ_WIDTH + 2);

   localparam logic [CNT_W-1:0] LAST_IDX     = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] MSG_LAST_IDX = CNT_W'(SEQ_WIDTH - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ENCODE = 2'd1;
   localparam logic [1:0] FLUSH  = 2'd2;

   logic [1:0]            fsm_q,   fsm_d;
   logic [SEQ_WIDTH-1:0]  msg_q,   msg_d;     // remaining bits, next one at MSB
   logic [1:0]            sr_q,    sr_d;      // {s1,s0}, s1 = newest bit
   logic [CNT_W-1:0]      cnt_q,   cnt_d;     // index of symbol on tx_data
   logic                  valid_q, valid_d;
   logic                  start_q, start_d;
   logic                  last_q,  last_d;
   logic [DATA_WIDTH-1:0] data_q,  data_d;

   logic             u_hs;
   logic             u_tx;
   logic [CNT_W-1:0] cnt_inc;

   // The message register shifts in zeros, so once the message bits are used
   // up the tail symbols automatically encode u=0.
   assign u_hs    = msg_data[SEQ_WIDTH-1];
   assign u_tx    = msg_q[SEQ_WIDTH-1];
   assign cnt_inc = cnt_q + CNT_W'(1);

   // Next-state logic: frame start on message handshake, advance on symbol transfer.
   always_comb begin
      fsm_d   = fsm_q;
      msg_d   = msg_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      start_d = start_q;
      last_d  = last_q;
      data_d  = data_q;
      case (fsm_q)
         IDLE: begin
            if (msg_valid) begin
               // First symbol is encoded from state 00, so c1 = c0 = u.
               msg_d   = msg_data << 1;
               sr_d    = {u_hs, 1'b0};
               data_d  = {u_hs, u_hs};
               cnt_d   = '0;
               valid_d = 1'b1;
               start_d = 1'b1;
               last_d  = (LAST_IDX == '0);
               fsm_d   = ENCODE;
            end
         end
         ENCODE, FLUSH: begin
            if (valid_q && tx_ready) begin
               if (cnt_q == LAST_IDX) begin
                  valid_d = 1'b0;
                  start_d = 1'b0;
                  last_d  = 1'b0;
                  data_d  = '0;
                  fsm_d   = IDLE;
               end else begin
                  msg_d   = msg_q << 1;
                  data_d  = {u_tx ^ sr_q[1] ^ sr_q[0], u_tx ^ sr_q[0]};
                  sr_d    = {u_tx, sr_q[1]};
                  cnt_d   = cnt_inc;
                  start_d = 1'b0;
                  last_d  = (cnt_inc == LAST_IDX);
                  if (fsm_q == ENCODE && cnt_q == MSG_LAST_IDX) begin
                     fsm_d = FLUSH;
                  end
               end
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   // State registers; reset aborts any frame in progress immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fsm_q   <= IDLE;
         msg_q   <= '0;
         sr_q    <= 2'b00;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         start_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         fsm_q   <= fsm_d;
         msg_q   <= msg_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         start_q <= start_d;
         last_q  <= last_d;
         data_q  <= data_d;
      end
   end

   assign msg_ready = (fsm_q == IDLE);
   assign tx_valid  = valid_q;
   assign tx_data   = data_q;
   assign tx_start  = start_q;
   assign tx_last   = last_q;
   assign enc_state = sr_q;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Bench for conv_encoder_framer: three instances (5 bits with tail, 5 bits
// without tail, 1 bit without tail) driven with shared stimulus and checked
// against a bit-level convolutional-code model.
module tb_conv_encoder_framer;

   typedef logic [3:0] ent_q_t[$];   // {c1,c0,s1,s0 after the symbol}

   logic       clk;
   logic       reset;
   logic       msg_valid;
   logic       c_msg_valid;
   logic [4:0] msg_data;
   logic       tx_ready;

   logic       o_ready[3];
   logic       o_valid[3];
   logic       o_start[3];
   logic       o_last[3];
   logic [1:0] o_data[3];
   logic [1:0] o_state[3];

   int checks;
   int errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   conv_encoder_framer #(.SEQ_WIDTH(5), .DATA_WIDTH(2), .TAIL_EN(1)) dut_a (
      .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_ready(o_ready[0]),
      .msg_data(msg_data), .tx_valid(o_valid[0]), .tx_ready(tx_ready),
      .tx_data(o_data[0]), .tx_start(o_start[0]), .tx_last(o_last[0]),
      .enc_state(o_state[0]));

   conv_encoder_framer #(.SEQ_WIDTH(5), .DATA_WIDTH(2), .TAIL_EN(0)) dut_b (
      .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_ready(o_ready[1]),
      .msg_data(msg_data), .tx_valid(o_valid[1]), .tx_ready(tx_ready),
      .tx_data(o_data[1]), .tx_start(o_start[1]), .tx_last(o_last[1]),
      .enc_state(o_state[1]));

   conv_encoder_framer #(.SEQ_WIDTH(1), .DATA_WIDTH(2), .TAIL_EN(0)) dut_c (
      .clk(clk), .reset(reset), .msg_valid(c_msg_valid), .msg_ready(o_ready[2]),
      .msg_data(msg_data[4:4]), .tx_valid(o_valid[2]), .tx_ready(tx_ready),
      .tx_data(o_data[2]), .tx_start(o_start[2]), .tx_last(o_last[2]),
      .enc_state(o_state[2]));

   // Reference: walk the message MSB-first (then zero tail bits) through a
   // K=3 shift register; c1 = u^s1^s0, c0 = u^s0, new state = {u,s1}.
   function automatic ent_q_t model(input logic [4:0] m, input int w, input bit tail);
      ent_q_t q;
      logic   s1, s0, u;
      int     n;
      s1 = 1'b0;
      s0 = 1'b0;
      n  = tail ? w + 2 : w;
      for (int i = 0; i < n; i++) begin
         u = (i < w) ? m[w-1-i] : 1'b0;
         q.push_back({u ^ s1 ^ s0, u ^ s0, u, s1});
         s0 = s1;
         s1 = u;
      end
      return q;
   endfunction

   // One frame on all three instances. mode 0: always ready, 1: ready 1,0,0
   // repeating, 2: random ready. poke holds msg_valid with other data while busy.
   task automatic run_frame(input logic [4:0] m, input int mode, input bit poke);
      ent_q_t     q;
      logic [3:0] e[3][8];
      int         n[3];
      int         idx[3];
      int         cyc;
      for (int j = 0; j < 3; j++) begin
         if (j == 0)      q = model(m, 5, 1'b1);
         else if (j == 1) q = model(m, 5, 1'b0);
         else             q = model({4'b0, m[4]}, 1, 1'b0);
         n[j]   = q.size();
         idx[j] = 0;
         for (int i = 0; i < n[j]; i++) e[j][i] = q[i];
      end
      cyc = 0;
      while (!(o_ready[0] && o_ready[1] && o_ready[2]) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (!(o_ready[0] && o_ready[1] && o_ready[2])) begin
         errors++;
         $display("FAIL idle_wait msg=%b ready=%b%b%b required 111", m, o_ready[0], o_ready[1], o_ready[2]);
         return;
      end
      msg_data    = m;
      msg_valid   = 1'b1;
      c_msg_valid = 1'b1;
      tx_ready    = 1'b1;
      @(negedge clk);
      msg_valid   = poke;
      c_msg_valid = 1'b0;
      if (poke) msg_data = ~m;
      cyc = 0;
      while ((idx[0] < n[0] || idx[1] < n[1] || idx[2] < n[2]) && cyc < 200) begin
         for (int j = 0; j < 3; j++) begin
            if (idx[j] < n[j]) begin
               checks++;
               if (o_valid[j] !== 1'b1) begin
                  errors++;
                  $display("FAIL valid inst=%0d msg=%b sym=%0d got=%b required 1", j, m, idx[j], o_valid[j]);
               end
               checks++;
               if ({o_data[j], o_state[j]} !== e[j][idx[j]]) begin
                  errors++;
                  $display("FAIL symbol inst=%0d msg=%b sym=%0d got data=%b state=%b required data=%b state=%b",
                           j, m, idx[j], o_data[j], o_state[j], e[j][idx[j]][3:2], e[j][idx[j]][1:0]);
               end
               checks++;
               if (o_start[j] !== (idx[j] == 0)) begin
                  errors++;
                  $display("FAIL start inst=%0d msg=%b sym=%0d got=%b required %b", j, m, idx[j], o_start[j], idx[j] == 0);
               end
               checks++;
               if (o_last[j] !== (idx[j] == n[j] - 1)) begin
                  errors++;
                  $display("FAIL last inst=%0d msg=%b sym=%0d got=%b required %b", j, m, idx[j], o_last[j], idx[j] == n[j] - 1);
               end
               checks++;
               if (o_ready[j] !== 1'b0) begin
                  errors++;
                  $display("FAIL busy_ready inst=%0d msg=%b sym=%0d got=%b required 0", j, m, idx[j], o_ready[j]);
               end
            end else begin
               checks++;
               if (o_valid[j] !== 1'b0) begin
                  errors++;
                  $display("FAIL post_valid inst=%0d msg=%b got=%b required 0", j, m, o_valid[j]);
               end
            end
         end
         case (mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (cyc % 3 == 0);
            default: tx_ready = 1'($urandom_range(0, 1));
         endcase
         if (tx_ready) begin
            for (int j = 0; j < 3; j++) if (idx[j] < n[j]) idx[j]++;
         end
         msg_valid = poke && (idx[1] < n[1]);
         cyc++;
         @(negedge clk);
      end
      msg_valid = 1'b0;
      tx_ready  = 1'b1;
      checks++;
      if (cyc >= 200) begin
         errors++;
         $display("FAIL frame_timeout msg=%b got cycles=%0d required <200", m, cyc);
      end
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (o_valid[j] !== 1'b0 || o_ready[j] !== 1'b1) begin
            errors++;
            $display("FAIL frame_end inst=%0d msg=%b got valid=%b ready=%b required valid=0 ready=1",
                     j, m, o_valid[j], o_ready[j]);
         end
      end
      $display("frame msg=%b mode=%0d poke=%0d cycles=%0d", m, mode, poke, cyc);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      for (int j = 0; j < 3; j++) begin
         checks++;
         if ({o_valid[j], o_start[j], o_last[j], o_data[j], o_state[j]} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs inst=%0d got v=%b s=%b l=%b d=%b st=%b required all 0",
                     j, o_valid[j], o_start[j], o_last[j], o_data[j], o_state[j]);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (o_ready[j] !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready inst=%0d got=%b required 1", j, o_ready[j]);
         end
      end
      $display("reset checked");
   endtask

   task automatic test_known();
      run_frame(5'b10110, 0, 1'b0);
      run_frame(5'b10000, 0, 1'b0);
      run_frame(5'b00000, 0, 1'b0);
   endtask

   task automatic test_stall();
      run_frame(5'b10110, 1, 1'b0);
      run_frame(5'b01011, 2, 1'b0);
   endtask

   task automatic test_busy_ignored();
      run_frame(5'b10110, 0, 1'b1);
      run_frame(5'b11111, 2, 1'b1);
   endtask

   task automatic test_random();
      repeat (10) run_frame(5'($urandom), 2, 1'($urandom_range(0, 1)));
   endtask

   task automatic test_back_to_back(input logic [4:0] m1, input logic [4:0] m2);
      ent_q_t     q1, q2;
      logic [3:0] e[16];
      int         ne, idx, k, hs, hs1, last_edge;
      q1 = model(m1, 5, 1'b1);
      q2 = model(m2, 5, 1'b1);
      ne = 0;
      for (int i = 0; i < q1.size(); i++) begin e[ne] = q1[i]; ne++; end
      for (int i = 0; i < q2.size(); i++) begin e[ne] = q2[i]; ne++; end
      k = 0;
      while (!(o_ready[0] && o_ready[1] && o_ready[2]) && k < 50) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (!o_ready[0]) begin
         errors++;
         $display("FAIL b2b_idle_wait got ready=%b required 1", o_ready[0]);
         return;
      end
      msg_data    = m1;
      msg_valid   = 1'b1;
      c_msg_valid = 1'b0;
      tx_ready    = 1'b1;
      hs = 1; hs1 = -1; last_edge = -1; idx = 0; k = 0;
      while ((hs < 2 || idx < ne) && k < 100) begin
         @(negedge clk);
         k++;
         if (hs == 1) msg_data = m2;
         if (hs >= 2) msg_valid = 1'b0;
         if (o_valid[0]) begin
            checks++;
            if (idx >= ne) begin
               errors++;
               $display("FAIL b2b_extra_symbol got data=%b required no symbol", o_data[0]);
            end else if ({o_data[0], o_state[0]} !== e[idx] || o_start[0] !== (idx == 0 || idx == 7)) begin
               errors++;
               $display("FAIL b2b_symbol sym=%0d got data=%b state=%b start=%b required data=%b state=%b start=%b",
                        idx, o_data[0], o_state[0], o_start[0], e[idx][3:2], e[idx][1:0], idx == 0 || idx == 7);
            end
            if (o_last[0] && last_edge < 0) last_edge = k;
            idx++;
         end
         if (msg_valid && o_ready[0]) begin
            if (hs == 1) hs1 = k;
            hs++;
         end
      end
      msg_valid = 1'b0;
      checks++;
      if (k >= 100) begin
         errors++;
         $display("FAIL b2b_timeout got cycles=%0d required <100", k);
      end
      checks++;
      if (hs1 !== last_edge + 1) begin
         errors++;
         $display("FAIL b2b_gap got accept_cycle=%0d required %0d", hs1, last_edge + 1);
      end
      $display("back_to_back m1=%b m2=%b last=%0d accept=%0d", m1, m2, last_edge, hs1);
   endtask

   task automatic test_reset_mid(input logic [4:0] m);
      int cyc;
      cyc = 0;
      while (!(o_ready[0] && o_ready[1] && o_ready[2]) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      msg_data    = m;
      msg_valid   = 1'b1;
      c_msg_valid = 1'b1;
      tx_ready    = 1'b1;
      @(negedge clk);
      msg_valid   = 1'b0;
      c_msg_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (o_valid[0] !== 1'b1) begin
         errors++;
         $display("FAIL midreset_busy got valid=%b required 1", o_valid[0]);
      end
      #2 reset = 1'b0;
      #1;
      for (int j = 0; j < 3; j++) begin
         checks++;
         if ({o_valid[j], o_start[j], o_last[j], o_data[j], o_state[j]} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_outputs inst=%0d got v=%b s=%b l=%b d=%b st=%b required all 0",
                     j, o_valid[j], o_start[j], o_last[j], o_data[j], o_state[j]);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (o_ready[j] !== 1'b1 || o_valid[j] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release inst=%0d got ready=%b valid=%b required ready=1 valid=0",
                     j, o_ready[j], o_valid[j]);
         end
      end
      $display("mid-frame reset msg=%b", m);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b0;
      msg_valid   = 1'b0;
      c_msg_valid = 1'b0;
      msg_data    = 5'b0;
      tx_ready    = 1'b0;
      test_reset();
      test_known();
      test_stall();
      test_busy_ignored();
      test_random();
      test_back_to_back(5'b10110, 5'b01101);
      test_reset_mid(5'b11011);
      run_frame(5'b10110, 2, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
